// File: rtl/retire_trace_buffer.sv
// Retire trace FIFO: records one {pc, instr, wdata, regwrite, seq} per retired
// instruction and drains them to a debug reader over valid/ready.
module retire_trace_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned SEQW  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [ILEN-1:0]          in_instr,
  input  logic [XLEN-1:0]          in_wdata,
  input  logic                     in_regwrite,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [ILEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_wdata,
  output logic                     out_regwrite,
  output logic [SEQW-1:0]          out_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [15:0]              overflow_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0] r_mem_pc    [DEPTH];
  logic [ILEN-1:0] r_mem_instr [DEPTH];
  logic [XLEN-1:0] r_mem_wdata [DEPTH];
  logic            r_mem_rw    [DEPTH];
  logic [SEQW-1:0] r_mem_seq   [DEPTH];

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [SEQW-1:0] r_seq;
  logic [15:0]     r_ovf;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = in_valid && (!w_full || w_pop);
  assign w_drop  = in_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem_pc[r_wr_ptr]    <= in_pc;
      r_mem_instr[r_wr_ptr] <= in_instr;
      r_mem_wdata[r_wr_ptr] <= in_wdata;
      r_mem_rw[r_wr_ptr]    <= in_regwrite;
      r_mem_seq[r_wr_ptr]   <= r_seq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_seq    <= '0;
      r_ovf    <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_seq    <= '0;
      r_ovf    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Sequence advances even on drops so lost records appear as gaps.
      if (in_valid) r_seq <= r_seq + SEQW'(1);
      if (w_drop && (r_ovf != 16'hFFFF)) r_ovf <= r_ovf + 16'd1;
    end
  end

  always_comb begin
    out_pc       = '0;
    out_instr    = '0;
    out_wdata    = '0;
    out_regwrite = 1'b0;
    out_seq      = '0;
    if (!w_empty) begin
      out_pc       = r_mem_pc[r_rd_ptr];
      out_instr    = r_mem_instr[r_rd_ptr];
      out_wdata    = r_mem_wdata[r_rd_ptr];
      out_regwrite = r_mem_rw[r_rd_ptr];
      out_seq      = r_mem_seq[r_rd_ptr];
    end
  end

  assign out_valid    = !w_empty;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign overflow_cnt = r_ovf;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer with hand-computed expected values.
module tb_retire_trace_buffer;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic [63:0] in_wdata;
  logic        in_regwrite;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [63:0] out_wdata;
  logic        out_regwrite;
  logic [31:0] out_seq;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] overflow_cnt;

  int n_cmp = 0;
  int n_err = 0;

  retire_trace_buffer #(
    .DEPTH(16), .XLEN(64), .ILEN(32), .SEQW(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_wdata(in_wdata), .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_wdata(out_wdata), .out_regwrite(out_regwrite),
    .out_seq(out_seq), .count(count), .full(full), .empty(empty),
    .overflow_cnt(overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Retire one record: instr = pc|0x13, wdata = ~pc, regwrite = pc[2].
  task automatic retire(input logic [63:0] pc);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_instr    = pc[31:0] | 32'h13;
    in_wdata    = ~pc;
    in_regwrite = pc[2];
    step();
    in_valid    = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  logic [63:0] exp_pc;

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_pc = '0;
    in_instr = '0; in_wdata = '0; in_regwrite = 1'b0; out_ready = 1'b0;
    #3;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full",  64'(full), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ovf",   64'(overflow_cnt), 64'd0);
    check("rst_pc",    out_pc, 64'd0);
    check("rst_seq",   64'(out_seq), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Three retires held, then drained in order
    retire(64'h0); retire(64'h4); retire(64'h8);
    check("t1_count", 64'(count), 64'd3);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_pc",    out_pc, 64'h0);
    check("t1_seq",   64'(out_seq), 64'd0);
    check("t1_instr", 64'(out_instr), 64'h13);
    check("t1_wdata", out_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t1_rw",    64'(out_regwrite), 64'd0);
    step(); step();
    check("t1_hold_pc",  out_pc, 64'h0);
    check("t1_hold_cnt", 64'(count), 64'd3);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t1_drain_pc",  out_pc, 64'(4 * k));
      check("t1_drain_seq", 64'(out_seq), 64'(k));
      if (k == 1) begin
        check("t1_wdata4", out_wdata, 64'hFFFF_FFFF_FFFF_FFFB);
        check("t1_rw4",    64'(out_regwrite), 64'd1);
      end
      step();
    end
    check("t1_empty", 64'(empty), 64'd1);
    step();
    check("t1_idle_cnt", 64'(count), 64'd0);
    out_ready = 1'b0;

    // One-edge latency, no bypass
    in_valid = 1'b1; in_pc = 64'h40; in_instr = 32'h53;
    in_wdata = ~64'h40; in_regwrite = 1'b0;
    check("t2_pre_valid", 64'(out_valid), 64'd0);
    step();
    in_valid = 1'b0;
    check("t2_valid", 64'(out_valid), 64'd1);
    check("t2_pc",    out_pc, 64'h40);
    check("t2_seq",   64'(out_seq), 64'd3);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("t2_empty", 64'(empty), 64'd1);

    // Overflow: 20 retires into 16 entries
    do_clear();
    for (int i = 0; i < 20; i++) retire(64'h100 + 64'(4 * i));
    check("t3_full",  64'(full), 64'd1);
    check("t3_count", 64'(count), 64'd16);
    check("t3_ovf",   64'(overflow_cnt), 64'd4);
    check("t3_seq0",  64'(out_seq), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("t3_drain_seq", 64'(out_seq), 64'(k));
      check("t3_drain_pc",  out_pc, 64'h100 + 64'(4 * k));
      step();
    end
    out_ready = 1'b0;
    check("t3_empty",    64'(empty), 64'd1);
    check("t3_ovf_keep", 64'(overflow_cnt), 64'd4);

    // Clear with a simultaneous retire and 5 entries held
    for (int i = 0; i < 5; i++) retire(64'h600 + 64'(4 * i));
    check("t5_count5", 64'(count), 64'd5);
    clear = 1'b1; in_valid = 1'b1; in_pc = 64'h777;
    step();
    clear = 1'b0; in_valid = 1'b0;
    check("t5_count", 64'(count), 64'd0);
    check("t5_empty", 64'(empty), 64'd1);
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_ovf",   64'(overflow_cnt), 64'd0);
    retire(64'h500);
    check("t5_seq", 64'(out_seq), 64'd0);
    check("t5_pc",  out_pc, 64'h500);

    // Full FIFO with push and pop together
    do_clear();
    for (int i = 0; i < 16; i++) retire(64'h200 + 64'(4 * i));
    check("t4_full", 64'(full), 64'd1);
    in_valid = 1'b1; in_pc = 64'h300; in_instr = 32'h313;
    in_wdata = ~64'h300; in_regwrite = 1'b0; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t4_count", 64'(count), 64'd16);
    check("t4_ovf",   64'(overflow_cnt), 64'd0);
    check("t4_head",  64'(out_seq), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp_pc = (k < 15) ? 64'h204 + 64'(4 * k) : 64'h300;
      check("t4_drain_seq", 64'(out_seq), 64'(k + 1));
      check("t4_drain_pc",  out_pc, exp_pc);
      step();
    end
    out_ready = 1'b0;
    check("t4_empty", 64'(empty), 64'd1);

    // Async reset mid-drain
    do_clear();
    for (int i = 0; i < 9; i++) retire(64'h700 + 64'(4 * i));
    out_ready = 1'b1; step(); step(); out_ready = 1'b0;
    check("t6_count7", 64'(count), 64'd7);
    check("t6_seq2",   64'(out_seq), 64'd2);
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_count", 64'(count), 64'd0);
    check("t6_pc",    out_pc, 64'd0);
    #3 rst_n = 1'b1;
    out_ready = 1'b0;
    step();
    retire(64'h800);
    check("t6_post_count", 64'(count), 64'd1);
    check("t6_post_seq",   64'(out_seq), 64'd0);
    check("t6_post_pc",    out_pc, 64'h800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
